rr_mux_arbiter: RTL

- Two-requester round-robin arbiter that shares the existing n-bit 2:1 `mux` datapath between source X and source Y.
- Feeds a single registered output stream with valid/ready handshakes.
- Arbitration is packet-based: a grant is held until the winner's beat with `last`=1 is accepted, so packets never interleave.
- Sits between two producers and one consumer; it is the block that drives the mux select.

---
 rtl/mux_arb_pkg.sv | 20 ++
 rtl/mux.sv | 20 ++
 rtl/rr_mux_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// ============================================================================
// mux_arb_pkg : shared types and source encodings for the round-robin arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_X = 2'd1,
        BURST_Y = 2'd2
    } arb_state_t;

    localparam logic SRC_X = 1'b1;
    localparam logic SRC_Y = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mux.sv
// ============================================================================
// mux      : n-bit 2:1 multiplexer, z = s ? a : b
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux #(
    parameter int n = 4
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    input  logic         s_i,
    output logic [n-1:0] z_o
);

    assign z_o = s_i ? a_i : b_i;

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// rr_mux_arbiter : packet-based two-source round-robin arbiter feeding one
//                  registered valid/ready output stream through a 2:1 mux
// Revision       : 1.0
// ============================================================================
`default_nettype none

module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         x_valid,
    input  logic [n-1:0] x_data,
    input  logic         x_last,
    output logic         x_ready,
    input  logic         y_valid,
    input  logic [n-1:0] y_data,
    input  logic         y_last,
    output logic         y_ready,
    output logic         z_valid,
    output logic [n-1:0] z_data,
    output logic         z_last,
    output logic         z_src,
    input  logic         z_ready,
    output logic         busy
);

    arb_state_t   state_q, state_d;
    logic         prio_q, prio_d;
    logic         z_valid_q;
    logic [n-1:0] z_data_q;
    logic         z_last_q;
    logic         z_src_q;

    logic         gnt_src;
    logic         gnt_vld;
    logic         load;
    logic         xfer;
    logic         win_last;
    logic [n-1:0] mux_z;

    // Grant: in IDLE a fresh round-robin decision, in a burst the owner is locked.
    always_comb begin
        gnt_src = SRC_Y;
        gnt_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (x_valid && (!y_valid || prio_q == SRC_X)) begin
                    gnt_src = SRC_X;
                    gnt_vld = 1'b1;
                end else if (y_valid) begin
                    gnt_src = SRC_Y;
                    gnt_vld = 1'b1;
                end
            end
            BURST_X: begin
                gnt_src = SRC_X;
                gnt_vld = x_valid;
            end
            BURST_Y: begin
                gnt_src = SRC_Y;
                gnt_vld = y_valid;
            end
            default: begin
                gnt_src = SRC_Y;
                gnt_vld = 1'b0;
            end
        endcase
    end

    assign load     = !z_valid_q || z_ready;
    assign xfer     = gnt_vld && load;
    assign x_ready  = xfer && (gnt_src == SRC_X);
    assign y_ready  = xfer && (gnt_src == SRC_Y);
    assign win_last = (gnt_src == SRC_X) ? x_last : y_last;

    mux #(
        .n (n)
    ) u_mux (
        .a_i (x_data),
        .b_i (y_data),
        .s_i (gnt_src),
        .z_o (mux_z)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (xfer) begin
            if (win_last) begin
                state_d = IDLE;
                prio_d  = ~gnt_src;
            end else begin
                state_d = (gnt_src == SRC_X) ? BURST_X : BURST_Y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= SRC_X;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Output register: payload fields hold their value while the slot drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_valid_q <= 1'b0;
            z_data_q  <= '0;
            z_last_q  <= 1'b0;
            z_src_q   <= SRC_Y;
        end else if (xfer) begin
            z_valid_q <= 1'b1;
            z_data_q  <= mux_z;
            z_last_q  <= win_last;
            z_src_q   <= gnt_src;
        end else if (z_ready) begin
            z_valid_q <= 1'b0;
        end
    end

    assign z_valid = z_valid_q;
    assign z_data  = z_data_q;
    assign z_last  = z_last_q;
    assign z_src   = z_src_q;
    assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire
